// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants and state encoding for the two-port memory arbiter.
// Used by the arbiter top and its busy/timeout timer.
package mem_port_arbiter_pkg;

    localparam int         XLEN         = 32;
    localparam logic [2:0] STARVE_LIMIT = 3'd4;
    localparam logic [7:0] TIMEOUT      = 8'd255;
    localparam logic [2:0] FUNCT3_WORD  = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_IF_BUSY = 2'd1,
        ST_D_BUSY  = 2'd2
    } state_t;

endpackage

// File: rtl/mem_arb_timer.sv
// Busy-cycle counter for the arbiter; flags the busy cycle that would
// bring the count to TIMEOUT so the owner can be released on that edge.
module mem_arb_timer
    import mem_port_arbiter_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic inc,
    output logic expired
);

    logic [7:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clear) begin
            r_cnt <= '0;
        end else if (inc && (r_cnt != TIMEOUT)) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    assign expired = inc && (r_cnt == (TIMEOUT - 8'd1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates a fetch port and a data port onto one memory port, data first,
// with a starvation guard for fetch and a busy timeout that sets a sticky err.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            enable,
    input  logic            if_req,
    input  logic [XLEN-1:0] if_addr,
    output logic [XLEN-1:0] if_rdata,
    output logic            if_valid,
    output logic            if_stall,
    input  logic            d_rd,
    input  logic            d_wr,
    input  logic [XLEN-1:0] d_addr,
    input  logic [XLEN-1:0] d_wdata,
    input  logic [2:0]      d_funct3,
    output logic [XLEN-1:0] d_rdata,
    output logic            d_valid,
    output logic            d_stall,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [2:0]      mem_funct3,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_ready,
    output logic            err
);

    state_t          r_state;
    logic [2:0]      r_starve;
    logic            r_mem_req;
    logic            r_mem_we;
    logic [XLEN-1:0] r_mem_addr;
    logic [XLEN-1:0] r_mem_wdata;
    logic [2:0]      r_mem_funct3;
    logic [XLEN-1:0] r_if_rdata;
    logic [XLEN-1:0] r_d_rdata;
    logic            r_if_valid;
    logic            r_d_valid;
    logic            r_err;

    logic w_d_pend;
    logic w_busy;
    logic w_idle_go;
    logic w_grant_d;
    logic w_grant_f;
    logic w_expired;
    logic w_done;

    assign w_d_pend  = d_rd | d_wr;
    assign w_busy    = (r_state != ST_IDLE);
    assign w_idle_go = (r_state == ST_IDLE) && enable;
    // Data wins unless fetch has been passed over STARVE_LIMIT times in a row.
    assign w_grant_d = w_idle_go && w_d_pend && !(if_req && (r_starve == STARVE_LIMIT));
    assign w_grant_f = w_idle_go && if_req && !w_grant_d;
    assign w_done    = w_busy && (mem_ready || w_expired);

    mem_arb_timer u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (w_grant_d | w_grant_f),
        .inc     (w_busy),
        .expired (w_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_starve     <= '0;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_mem_funct3 <= '0;
            r_if_rdata   <= '0;
            r_d_rdata    <= '0;
            r_if_valid   <= 1'b0;
            r_d_valid    <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_if_valid <= 1'b0;
            r_d_valid  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_d) begin
                        r_state      <= ST_D_BUSY;
                        r_mem_req    <= 1'b1;
                        r_mem_we     <= d_wr;
                        r_mem_addr   <= d_addr;
                        r_mem_wdata  <= d_wdata;
                        r_mem_funct3 <= d_funct3;
                        if (if_req && (r_starve != STARVE_LIMIT)) begin
                            r_starve <= r_starve + 3'd1;
                        end
                    end else if (w_grant_f) begin
                        r_state      <= ST_IF_BUSY;
                        r_mem_req    <= 1'b1;
                        r_mem_we     <= 1'b0;
                        r_mem_addr   <= if_addr;
                        r_mem_wdata  <= '0;
                        r_mem_funct3 <= FUNCT3_WORD;
                        r_starve     <= '0;
                    end
                end
                ST_IF_BUSY, ST_D_BUSY: begin
                    if (w_done) begin
                        r_state   <= ST_IDLE;
                        r_mem_req <= 1'b0;
                        // Writes and timeouts return zero data to the owner.
                        if (r_state == ST_IF_BUSY) begin
                            r_if_valid <= 1'b1;
                            r_if_rdata <= (mem_ready && !r_mem_we) ? mem_rdata : '0;
                        end else begin
                            r_d_valid <= 1'b1;
                            r_d_rdata <= (mem_ready && !r_mem_we) ? mem_rdata : '0;
                        end
                        if (!mem_ready) begin
                            r_err <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_mem_req <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req    = r_mem_req;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign mem_funct3 = r_mem_funct3;
    assign if_rdata   = r_if_rdata;
    assign d_rdata    = r_d_rdata;
    assign if_valid   = r_if_valid;
    assign d_valid    = r_d_valid;
    assign err        = r_err;
    assign if_stall   = if_req & ~r_if_valid;
    assign d_stall    = w_d_pend & ~r_d_valid;

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-002 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port enable  input  1  when low, no new grant is issued; an in-flight transaction still completes.
REQ-004 SHALL have ports if_req (in 1, fetch request), if_addr (in 32), if_rdata (out 32), if_valid (out 1, one-cycle completion pulse), if_stall (out 1).
REQ-005 SHALL have ports d_rd (in 1), d_wr (in 1), d_addr (in 32), d_wdata (in 32), d_funct3 (in 3, access size/sign), d_rdata (out 32), d_valid (out 1), d_stall (out 1).
REQ-006 SHALL have memory-side ports mem_req (out 1), mem_we (out 1), mem_addr (out 32), mem_wdata (out 32), mem_funct3 (out 3), mem_rdata (in 32), mem_ready (in 1).
REQ-007 SHALL have port err  output  1  sticky timeout flag.

Function
REQ-008 SHALL implement states IDLE, IF_BUSY, D_BUSY.
REQ-009 In IDLE with enable=1, SHALL grant data if (d_rd|d_wr), else fetch if if_req, else stay IDLE.
REQ-010 When both requesters are pending and starve_cnt==4, SHALL grant fetch instead of data.
REQ-011 starve_cnt (3 bits) SHALL increment on each data grant while if_req=1, saturate at 4, and clear on any fetch grant.
REQ-012 On grant, SHALL latch address, wdata, funct3 and we (we=d_wr; d_wr takes precedence over d_rd) and enter the busy state at the same edge.
REQ-013 mem_req SHALL be a registered output that is high in every busy-state cycle; mem_addr, mem_we, mem_wdata and mem_funct3 SHALL hold stable until mem_ready.
REQ-014 On mem_ready=1 in a busy state, SHALL register mem_rdata into the owning rdata output (0 for writes), pulse that port's valid for exactly one cycle, and return to IDLE.
REQ-015 Latency: a request at cycle N with mem_ready at N+1 SHALL yield valid at N+2; a new grant SHALL be evaluated in the IDLE cycle that coincides with valid.
REQ-016 if_stall SHALL equal if_req & ~if_valid; d_stall SHALL equal (d_rd|d_wr) & ~d_valid (combinational).
REQ-017 An 8-bit busy counter SHALL clear on grant and increment each busy cycle; if it reaches 255 without mem_ready, SHALL return to IDLE, pulse the owner's valid with rdata=0, and set err.
REQ-018 mem_ready in IDLE SHALL be ignored.
REQ-019 rdata outputs SHALL hold their last value between valid pulses.

Reset
REQ-020 On rst, SHALL force state IDLE, mem_req=0, mem_we=0, if_valid=d_valid=0, if_rdata=d_rdata=0, mem_addr=mem_wdata=0, mem_funct3=0, starve_cnt=0, busy counter=0, err=0, including when rst arrives mid-transaction; a mem_ready in the reset cycle SHALL be discarded.

Structure
REQ-021 SHALL place the state encoding, STARVE_LIMIT=4, TIMEOUT=255 and XLEN=32 in a shared package.
REQ-022 SHALL instantiate the busy/timeout counter as sub-module mem_arb_timer (clear, inc, expired).

Verification
REQ-023 Single fetch: if_req=1, if_addr=0x10, mem_ready at the first mem_req cycle, mem_rdata=0x00500093 -> if_valid two cycles after the request with if_rdata=0x00500093, mem_we=0.
REQ-024 Simultaneous: if_req and d_rd (d_addr=0x200) held together for 6 transactions -> grant order D,D,D,D,F,D.
REQ-025 Store: d_wr=1, d_addr=0x44, d_wdata=0xDEADBEEF, d_funct3=3'b010, mem_ready delayed 3 cycles -> mem_we=1 and fields stable for 3 cycles, then d_valid with d_rdata=0.
REQ-026 Timeout: d_rd with mem_ready never asserted -> d_valid after 255 busy cycles, d_rdata=0, err=1 until rst.
REQ-027 Reset mid-op: rst during D_BUSY with mem_ready=1 in the same cycle -> no d_valid, mem_req=0 next cycle, state IDLE.
REQ-028 enable=0 with if_req=1 -> no mem_req; enable set to 1 -> mem_req on the next cycle.
